contador_credito: RTL and testbench
===================================

Name: contador_credito

Overview:
- Parametrised, single-clock successor of the coin-counting block in the coffee-machine datapath.
- Accumulates credit from two coin inputs with configurable values and saturates at the maximum count.
- Handles a purchase request against a fixed price and returns change through a valid/ack handshake.
- Sits between the coin acceptor front end and the dispenser/display logic.

Parameters:
- N, 4, width of the credit and change values; maximum credit MAX = 2^N-1.
- VALOR_A, 1, credit units added per moneda100 edge.
- VALOR_B, 5, credit units added per moneda500 edge.
- PRECIO, 3, credit units consumed per purchase; legal range 1..MAX.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- moneda100  input  1  coin-A level, synchronous to clk; counted on its 0->1 transition.
- moneda500  input  1  coin-B level, synchronous to clk; counted on its 0->1 transition.
- comprar  input  1  purchase request, sampled each cycle.
- cancelar  input  1  refund request, sampled each cycle.
- vuelto_ack  input  1  consumer accepts the change value.
- estado  output  N  current credit.
- listo  output  1  combinational: estado >= PRECIO and FSM in IDLE.
- servir  output  1  one-cycle dispense pulse.
- vuelto  output  N  change amount; meaningful only while vuelto_valido = 1.
- vuelto_valido  output  1  change-offer valid, held until ack.
- rechazo  output  1  one-cycle pulse when a coin edge is discarded.
- insuficiente  output  1  one-cycle pulse when comprar arrives with estado < PRECIO.
- saturado  output  1  one-cycle pulse when an addition was clipped at MAX.

Behaviour:
- Reset (synchronous, active-high), values after the clock edge:
  - FSM = IDLE; estado = 0; vuelto = 0.
  - servir, vuelto_valido, rechazo, insuficiente and saturado = 0.
  - Coin edge-detect registers load the current moneda100/moneda500 levels, so a coin held high across reset release is not counted.
- Edge detection: an edge is valid in cycle k when the input is 1 at edge k and was 0 at edge k-1. A held level counts once.
- Latency: one cycle. A valid edge at clock edge k updates estado at that edge; the new value is visible from cycle k+1.
- FSM states: IDLE, SERVIR, VUELTO.
- IDLE, checked in priority order:
  1. cancelar=1 and estado>0: vuelto <= estado, go to VUELTO.
  2. cancelar=1 and estado=0: no-op.
  3. comprar=1 and estado>=PRECIO: estado <= estado-PRECIO, go to SERVIR.
  4. comprar=1 and estado<PRECIO: pulse insuficiente; estado unchanged; coins in the same cycle still accepted.
  5. Otherwise accept coins. Add = VALOR_A if a moneda100 edge, plus VALOR_B if a moneda500 edge; both in one cycle add the sum. Compute in N+1 bits; if the result > MAX then estado <= MAX and pulse saturado.
  - If a cancel or purchase is accepted (cases 1 and 3), any coin edge in the same cycle is discarded and rechazo pulses.
- SERVIR (exactly 1 cycle):
  - servir=1.
  - Next state is VUELTO with vuelto <= estado if estado>0, otherwise IDLE.
- VUELTO:
  - vuelto_valido=1 and vuelto stays stable until vuelto_ack=1 is sampled.
  - On ack: estado <= 0, vuelto_valido <= 0, go to IDLE.
  - vuelto_ack outside VUELTO is ignored.
- In SERVIR and VUELTO:
  - Coin edges are discarded with a rechazo pulse per edge.
  - comprar and cancelar are ignored.
- At saturation (estado = MAX), further coins leave estado at MAX and pulse saturado. They are not rechazo.
- Reset in any state, including mid-VUELTO, aborts immediately to the reset values. Pending change is lost.
- All outputs except listo are registered.

Test Plan (N=4, VALOR_A=1, VALOR_B=5, PRECIO=3):
1. Reset, then three separate moneda100 pulses -> estado 1,2,3, each one cycle after its edge; listo=1 after the third.
2. moneda100 and moneda500 rise on the same edge from estado=0 -> estado=6. moneda500 then held high 10 cycles -> estado stays 6.
3. estado=12, moneda500 edge -> estado=15 and one saturado pulse. Another moneda100 edge -> estado=15, saturado pulses again, rechazo=0.
4. estado=7, comprar -> servir=1 for one cycle and estado=4, then vuelto_valido=1 with vuelto=4. Hold ack low 5 cycles -> outputs unchanged; a coin edge during this wait gives a rechazo pulse with estado=4. ack=1 -> estado=0, FSM back in IDLE.
5. estado=2, comprar -> insuficiente pulse, estado=2. Then comprar and cancelar together -> cancel wins, vuelto=2; ack -> estado=0.
6. Assert reset in VUELTO with vuelto=4 while moneda100 is held high -> estado=0, vuelto_valido=0. After release with moneda100 still high -> no count until the line falls and rises again.

Source files
------------

// File: rtl/contador_credito.sv
// Credit counter for the coffee-machine datapath: accumulates coin credit,
// serves purchases at a fixed price and offers change through a valid/ack handshake.
//
// state  | meaning
// IDLE   | accepting coins, purchase and cancel requests
// SERVIR | one-cycle dispense pulse after an accepted purchase
// VUELTO | change offered on vuelto, waiting for vuelto_ack
module contador_credito #(
    parameter int N       = 4,
    parameter int VALOR_A = 1,
    parameter int VALOR_B = 5,
    parameter int PRECIO  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         moneda100,
    input  logic         moneda500,
    input  logic         comprar,
    input  logic         cancelar,
    input  logic         vuelto_ack,
    output logic [N-1:0] estado,
    output logic         listo,
    output logic         servir,
    output logic [N-1:0] vuelto,
    output logic         vuelto_valido,
    output logic         rechazo,
    output logic         insuficiente,
    output logic         saturado
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVIR = 2'd1,
        VUELTO = 2'd2
    } fsm_t;

    // Two guard bits so that MAX plus both coin values can never wrap.
    localparam logic [N+1:0] MAX_W = (N+2)'((2 ** N) - 1);
    localparam logic [N+1:0] VA    = (N+2)'(VALOR_A);
    localparam logic [N+1:0] VB    = (N+2)'(VALOR_B);
    localparam logic [N-1:0] PR    = N'(PRECIO);

    fsm_t         fsm, fsm_sig;
    logic         m100_prev, m500_prev;
    logic         flanco_a, flanco_b, hay_flanco;
    logic         acepta_monedas;
    logic [N+1:0] suma;
    logic [N-1:0] estado_sig, vuelto_sig;
    logic         vv_sig, servir_sig, rechazo_sig, insuf_sig, sat_sig;

    assign flanco_a   = moneda100 & ~m100_prev;
    assign flanco_b   = moneda500 & ~m500_prev;
    assign hay_flanco = flanco_a | flanco_b;
    assign suma       = {2'b00, estado} + (flanco_a ? VA : '0) + (flanco_b ? VB : '0);
    assign listo      = (estado >= PR) && (fsm == IDLE);

    always_comb begin
        fsm_sig        = fsm;
        estado_sig     = estado;
        vuelto_sig     = vuelto;
        vv_sig         = vuelto_valido;
        servir_sig     = 1'b0;
        rechazo_sig    = 1'b0;
        insuf_sig      = 1'b0;
        sat_sig        = 1'b0;
        acepta_monedas = 1'b0;

        case (fsm)
            IDLE: begin
                if (cancelar && (estado != '0)) begin
                    vuelto_sig  = estado;
                    vv_sig      = 1'b1;
                    fsm_sig     = VUELTO;
                    rechazo_sig = hay_flanco;
                end else if (cancelar) begin
                    acepta_monedas = 1'b1;
                end else if (comprar && (estado >= PR)) begin
                    estado_sig  = estado - PR;
                    servir_sig  = 1'b1;
                    fsm_sig     = SERVIR;
                    rechazo_sig = hay_flanco;
                end else begin
                    insuf_sig      = comprar;
                    acepta_monedas = 1'b1;
                end
            end
            SERVIR: begin
                rechazo_sig = hay_flanco;
                if (estado != '0) begin
                    vuelto_sig = estado;
                    vv_sig     = 1'b1;
                    fsm_sig    = VUELTO;
                end else begin
                    fsm_sig = IDLE;
                end
            end
            VUELTO: begin
                rechazo_sig = hay_flanco;
                if (vuelto_ack) begin
                    estado_sig = '0;
                    vv_sig     = 1'b0;
                    fsm_sig    = IDLE;
                end
            end
            default: begin
                fsm_sig = IDLE;
            end
        endcase

        if (acepta_monedas && hay_flanco) begin
            if (suma > MAX_W) begin
                estado_sig = {N{1'b1}};
                sat_sig    = 1'b1;
            end else begin
                estado_sig = suma[N-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm           <= IDLE;
            estado        <= '0;
            vuelto        <= '0;
            vuelto_valido <= 1'b0;
            servir        <= 1'b0;
            rechazo       <= 1'b0;
            insuficiente  <= 1'b0;
            saturado      <= 1'b0;
            // A coin already high at release must not count as an edge.
            m100_prev     <= moneda100;
            m500_prev     <= moneda500;
        end else begin
            fsm           <= fsm_sig;
            estado        <= estado_sig;
            vuelto        <= vuelto_sig;
            vuelto_valido <= vv_sig;
            servir        <= servir_sig;
            rechazo       <= rechazo_sig;
            insuficiente  <= insuf_sig;
            saturado      <= sat_sig;
            m100_prev     <= moneda100;
            m500_prev     <= moneda500;
        end
    end

endmodule

// File: tb/tb_contador_credito.sv
// Directed bench for contador_credito: expected credit values go into a scoreboard
// queue as stimulus is driven and are popped when the DUT output is sampled.
module tb_contador_credito;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset, moneda100, moneda500, comprar, cancelar, vuelto_ack;
    logic [N-1:0] estado, vuelto;
    logic         listo, servir, vuelto_valido, rechazo, insuficiente, saturado;

    int n_assert = 0;
    int n_fail   = 0;
    int sb_q[$];

    contador_credito #(.N(N), .VALOR_A(1), .VALOR_B(5), .PRECIO(3)) dut (
        .clk(clk), .reset(reset),
        .moneda100(moneda100), .moneda500(moneda500),
        .comprar(comprar), .cancelar(cancelar), .vuelto_ack(vuelto_ack),
        .estado(estado), .listo(listo), .servir(servir),
        .vuelto(vuelto), .vuelto_valido(vuelto_valido),
        .rechazo(rechazo), .insuficiente(insuficiente), .saturado(saturado)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int v);
        sb_q.push_back(v);
    endtask

    task automatic sb_check(input string tag);
        int e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 8'(estado), 8'(e));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Single coin pulse: rise, sample, fall.
    task automatic coin(input logic a, input logic b, input int exp_estado, input string tag);
        moneda100 = a;
        moneda500 = b;
        sb_push(exp_estado);
        step();
        sb_check(tag);
        moneda100 = 1'b0;
        moneda500 = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; moneda100 = 1'b0; moneda500 = 1'b0;
        comprar = 1'b0; cancelar = 1'b0; vuelto_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_estado", 8'(estado), 8'd0);
        chk("rst_vuelto", 8'(vuelto), 8'd0);
        chk("rst_vv", 8'(vuelto_valido), 8'd0);
        chk("rst_servir", 8'(servir), 8'd0);
        chk("rst_listo", 8'(listo), 8'd0);

        // 1: three single coin-A pulses
        coin(1'b1, 1'b0, 1, "t1_estado1");
        coin(1'b1, 1'b0, 2, "t1_estado2");
        chk("t1_listo_low", 8'(listo), 8'd0);
        coin(1'b1, 1'b0, 3, "t1_estado3");
        chk("t1_listo_high", 8'(listo), 8'd1);

        // 2: both coins together, then coin-B held high
        do_reset();
        chk("t2_cleared", 8'(estado), 8'd0);
        moneda100 = 1'b1; moneda500 = 1'b1;
        sb_push(6);
        step();
        sb_check("t2_both");
        moneda100 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_held", 8'(estado), 8'd6);
        end
        moneda500 = 1'b0;
        step();

        // 3: saturation at MAX
        coin(1'b0, 1'b1, 11, "t3_to11");
        coin(1'b1, 1'b0, 12, "t3_to12");
        moneda500 = 1'b1;
        sb_push(15);
        step();
        sb_check("t3_sat_b");
        chk("t3_saturado_b", 8'(saturado), 8'd1);
        chk("t3_rechazo_b", 8'(rechazo), 8'd0);
        moneda500 = 1'b0;
        step();
        chk("t3_saturado_clr", 8'(saturado), 8'd0);
        moneda100 = 1'b1;
        sb_push(15);
        step();
        sb_check("t3_sat_a");
        chk("t3_saturado_a", 8'(saturado), 8'd1);
        chk("t3_rechazo_a", 8'(rechazo), 8'd0);
        moneda100 = 1'b0;
        step();

        // 4: purchase with change, held offer, coin rejected while waiting
        do_reset();
        coin(1'b0, 1'b1, 5, "t4_to5");
        coin(1'b1, 1'b0, 6, "t4_to6");
        coin(1'b1, 1'b0, 7, "t4_to7");
        comprar = 1'b1;
        sb_push(4);
        step();
        comprar = 1'b0;
        sb_check("t4_after_buy");
        chk("t4_servir", 8'(servir), 8'd1);
        chk("t4_listo_busy", 8'(listo), 8'd0);
        step();
        chk("t4_servir_end", 8'(servir), 8'd0);
        chk("t4_vv", 8'(vuelto_valido), 8'd1);
        chk("t4_vuelto", 8'(vuelto), 8'd4);
        moneda100 = 1'b1;
        step();
        chk("t4_rechazo", 8'(rechazo), 8'd1);
        chk("t4_estado_wait", 8'(estado), 8'd4);
        moneda100 = 1'b0;
        step();
        chk("t4_rechazo_clr", 8'(rechazo), 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_vv_hold", 8'(vuelto_valido), 8'd1);
            chk("t4_vuelto_hold", 8'(vuelto), 8'd4);
        end
        vuelto_ack = 1'b1;
        sb_push(0);
        step();
        vuelto_ack = 1'b0;
        sb_check("t4_ack");
        chk("t4_vv_clr", 8'(vuelto_valido), 8'd0);
        coin(1'b1, 1'b0, 1, "t4_idle_again");

        // 5: insufficient credit, then cancel beats purchase
        coin(1'b1, 1'b0, 2, "t5_to2");
        comprar = 1'b1;
        sb_push(2);
        step();
        comprar = 1'b0;
        sb_check("t5_insuf_estado");
        chk("t5_insuf", 8'(insuficiente), 8'd1);
        step();
        chk("t5_insuf_clr", 8'(insuficiente), 8'd0);
        comprar = 1'b1; cancelar = 1'b1;
        step();
        comprar = 1'b0; cancelar = 1'b0;
        chk("t5_cancel_vv", 8'(vuelto_valido), 8'd1);
        chk("t5_cancel_vuelto", 8'(vuelto), 8'd2);
        chk("t5_no_servir", 8'(servir), 8'd0);
        vuelto_ack = 1'b1;
        sb_push(0);
        step();
        vuelto_ack = 1'b0;
        sb_check("t5_ack");

        // 6: reset during change offer with coin-A held high
        coin(1'b0, 1'b1, 5, "t6_to5");
        coin(1'b1, 1'b0, 6, "t6_to6");
        coin(1'b1, 1'b0, 7, "t6_to7");
        comprar = 1'b1;
        step();
        comprar = 1'b0;
        step();
        chk("t6_vuelto", 8'(vuelto), 8'd4);
        moneda100 = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_estado", 8'(estado), 8'd0);
        chk("t6_rst_vv", 8'(vuelto_valido), 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_held_nocount", 8'(estado), 8'd0);
        end
        moneda100 = 1'b0;
        step();
        coin(1'b1, 1'b0, 1, "t6_recount");

        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
